// File: rtl/h264nc_predict_if.sv
// h264nc_predict_if: block-position, TotalCoeff writeback and nC result
// signals shared between the coefficient buffer / CAVLC side (master)
// and the nC predictor (slave).
//
// Handshake: no back-pressure anywhere. NLOAD, NXINC, TCVALID, NEWLINE
// and NEWSLICE are single-cycle strobes sampled on the rising clock
// edge. NOUTVALID is a single-cycle strobe qualifying NOUT, raised two
// cycles after the NLOAD that requested it.
interface h264nc_predict_if;
    logic       NEWSLICE;
    logic       NEWLINE;
    logic       NLOAD;
    logic [2:0] NX;
    logic [2:0] NY;
    logic [1:0] NV;
    logic       NXINC;
    logic       TCVALID;
    logic [4:0] TOTALCOEFF;
    logic [4:0] NOUT;
    logic       NOUTVALID;
    logic       TCERR;

    modport master (
        output NEWSLICE, NEWLINE, NLOAD, NX, NY, NV, NXINC, TCVALID, TOTALCOEFF,
        input  NOUT, NOUTVALID, TCERR
    );

    modport slave (
        input  NEWSLICE, NEWLINE, NLOAD, NX, NY, NV, NXINC, TCVALID, TOTALCOEFF,
        output NOUT, NOUTVALID, TCERR
    );
endinterface

// File: rtl/h264nc_predict.sv
// h264nc_predict: neighbour TotalCoeff store and nC predictor for CAVLC.
// Holds the current-MB TotalCoeff grid (16 luma + 4 Cb + 4 Cr), the
// left-neighbour column and a per-MB-column top row for one picture row.
// Lookup: NLOAD latches a position, the next cycle reads nA/nB, and the
// registered nC appears with NOUTVALID one cycle after that.
//
// Optional macro NC_TCCHECK_EN: flags TOTALCOEFF > 16 on TCERR (sticky)
// and stores the value clamped to 16. Without it TCERR is tied low.
//
// Grid index: luma {0,y[1:0],x[1:0]}; chroma {2'b10,cr,y,x}.
// Left index: luma {0,y[1:0]}; chroma {1,cr,y}.
// Top word: eight 5-bit fields, field k at [5k+4:5k];
//   k=0..3 luma bottom row x=k, k=4..5 Cb bottom row, k=6..7 Cr bottom row.
module h264nc_predict #(
    parameter int MAXMBW = 120,
    parameter int MBXW   = 7
) (
    input logic           CLK,
    input logic           RSTN,
    h264nc_predict_if.slave bus
);

    logic [4:0]      cur      [24];
    logic [4:0]      cur_fwd  [24];
    logic [4:0]      left_col [8];
    logic [39:0]     top_mem  [MAXMBW];
    logic [39:0]     top_rd;
    logic [4:0]      top_f    [8];
    logic [39:0]     commit_word;

    logic [MBXW-1:0] mbx;
    logic            lat_ch;
    logic [1:0]      lat_x;
    logic [1:0]      lat_y;
    logic [1:0]      lat_nv;
    logic            p1_v;

    logic [4:0]      wr_idx;
    logic [4:0]      tc_val;
    logic            tc_we;
    logic            commit_we;
    logic [1:0]      xm1;
    logic [1:0]      ym1;
    logic [4:0]      na;
    logic [4:0]      nb;
    logic [5:0]      sum;
    logic [4:0]      nc;
    logic [4:0]      nout_q;
    logic            noutvalid_q;

    assign tc_we     = bus.TCVALID && !bus.NEWSLICE;
    assign commit_we = bus.NXINC && !bus.NEWSLICE;
    assign wr_idx    = lat_ch ? {2'b10, lat_y, lat_x[0]} : {1'b0, lat_y, lat_x};
    assign xm1       = lat_x - 2'd1;
    assign ym1       = lat_y - 2'd1;

`ifdef NC_TCCHECK_EN
    logic tc_over;
    logic tcerr_q;
    assign tc_over = bus.TOTALCOEFF > 5'd16;
    assign tc_val  = tc_over ? 5'd16 : bus.TOTALCOEFF;
    assign bus.TCERR = tcerr_q;

    // Sticky range flag, cleared only by reset or slice start.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)
            tcerr_q <= 1'b0;
        else if (bus.NEWSLICE)
            tcerr_q <= 1'b0;
        else if (bus.TCVALID && tc_over)
            tcerr_q <= 1'b1;
    end
`else
    assign tc_val    = bus.TOTALCOEFF;
    assign bus.TCERR = 1'b0;
`endif

    // Grid as seen this cycle, with a same-cycle TotalCoeff write folded in.
    always_comb begin
        for (int i = 0; i < 24; i++) begin
            cur_fwd[i] = (tc_we && (wr_idx == 5'(i))) ? tc_val : cur[i];
        end
    end

    // Bottom rows of the current MB packed into one top-memory word.
    always_comb begin
        commit_word = {cur_fwd[23], cur_fwd[22], cur_fwd[19], cur_fwd[18],
                       cur_fwd[15], cur_fwd[14], cur_fwd[13], cur_fwd[12]};
    end

    // Top-memory read port; a same-cycle commit to mbx returns the new word.
    always_comb begin
        top_rd = commit_we ? commit_word : top_mem[mbx];
        for (int k = 0; k < 8; k++) begin
            top_f[k] = top_rd[k*5 +: 5];
        end
    end

    // Neighbour fetch for the latched block, then the availability-based nC.
    always_comb begin
        na = 5'd0;
        nb = 5'd0;
        if (lat_ch) begin
            na = lat_x[0] ? cur_fwd[{2'b10, lat_y[1], lat_y[0], 1'b0}]
                          : left_col[{1'b1, lat_y[1], lat_y[0]}];
            nb = lat_y[0] ? cur_fwd[{2'b10, lat_y[1], 1'b0, lat_x[0]}]
                          : top_f[{1'b1, lat_y[1], lat_x[0]}];
        end else begin
            na = (lat_x != 2'd0) ? cur_fwd[{1'b0, lat_y, xm1}] : left_col[{1'b0, lat_y}];
            nb = (lat_y != 2'd0) ? cur_fwd[{1'b0, ym1, lat_x}] : top_f[{1'b0, lat_x}];
        end
        sum = {1'b0, na} + {1'b0, nb} + 6'd1;
        case (lat_nv)
            2'b11:   nc = sum[5:1];
            2'b01:   nc = na;
            2'b10:   nc = nb;
            default: nc = 5'd0;
        endcase
    end

    // Current grid, left column, column counter, latched position and result.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN || bus.NEWSLICE) begin
            for (int i = 0; i < 24; i++) cur[i] <= 5'd0;
            for (int i = 0; i < 8; i++) left_col[i] <= 5'd0;
            mbx         <= '0;
            lat_ch      <= 1'b0;
            lat_x       <= 2'd0;
            lat_y       <= 2'd0;
            lat_nv      <= 2'd0;
            p1_v        <= 1'b0;
            nout_q      <= 5'd0;
            noutvalid_q <= 1'b0;
        end else begin
            if (tc_we)
                cur[wr_idx] <= tc_val;

            if (bus.NEWLINE) begin
                for (int i = 0; i < 8; i++) left_col[i] <= 5'd0;
            end else if (bus.NXINC) begin
                left_col[0] <= cur_fwd[3];
                left_col[1] <= cur_fwd[7];
                left_col[2] <= cur_fwd[11];
                left_col[3] <= cur_fwd[15];
                left_col[4] <= cur_fwd[17];
                left_col[5] <= cur_fwd[19];
                left_col[6] <= cur_fwd[21];
                left_col[7] <= cur_fwd[23];
            end

            if (bus.NEWLINE)
                mbx <= '0;
            else if (bus.NXINC)
                mbx <= (mbx == MBXW'(MAXMBW - 1)) ? '0 : mbx + 1'b1;

            if (bus.NLOAD) begin
                lat_ch <= bus.NX[2] | bus.NY[2];
                lat_x  <= bus.NX[1:0];
                lat_y  <= bus.NY[1:0];
                lat_nv <= bus.NV;
            end
            p1_v        <= bus.NLOAD;
            noutvalid_q <= p1_v;
            if (p1_v)
                nout_q <= nc;
        end
    end

    // Top-row memory write port: one word per committed MB column.
    always_ff @(posedge CLK) begin
        if (commit_we)
            top_mem[mbx] <= commit_word;
    end

    assign bus.NOUT      = nout_q;
    assign bus.NOUTVALID = noutvalid_q;

endmodule

// File: tb/tb_h264nc_predict.sv
// tb_h264nc_predict: directed stimulus for the nC predictor with a
// position-level model (x/y grids, left column, per-column top row) and a
// per-cycle compare process, plus literal expectations pinning the model.
module tb_h264nc_predict;
    localparam int MAXMBW = 120;
    localparam int MBXW   = 7;

    logic CLK  = 1'b0;
    logic RSTN = 1'b0;
    always #5 CLK = ~CLK;

    h264nc_predict_if bus();

    h264nc_predict #(.MAXMBW(MAXMBW), .MBXW(MBXW)) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model state
    int   m_luma   [4][4];        // [x][y]
    int   m_chroma [2][2][2];     // [cr][x][y]
    int   m_left_l [4];           // [y]
    int   m_left_c [2][2];        // [cr][y]
    int   m_top_l  [MAXMBW][4];   // [mb][x]
    int   m_top_c  [MAXMBW][2][2];// [mb][cr][x]
    int   m_mbx;
    bit   m_pend;
    bit   m_ch;
    int   m_c, m_x, m_y;
    logic [1:0] m_nv;
    bit   m_exp_v;
    bit   m_err;
    logic [4:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear_grid();
        for (int x = 0; x < 4; x++) for (int y = 0; y < 4; y++) m_luma[x][y] = 0;
        for (int c = 0; c < 2; c++) for (int x = 0; x < 2; x++) for (int y = 0; y < 2; y++)
            m_chroma[c][x][y] = 0;
    endtask

    task automatic model_clear_left();
        for (int y = 0; y < 4; y++) m_left_l[y] = 0;
        for (int c = 0; c < 2; c++) for (int y = 0; y < 2; y++) m_left_c[c][y] = 0;
    endtask

    task automatic model_clear();
        model_clear_grid();
        model_clear_left();
        m_mbx = 0; m_pend = 0; m_ch = 0; m_c = 0; m_x = 0; m_y = 0; m_nv = 2'b00;
        m_exp_v = 0; m_err = 0;
        exp_q.delete();
    endtask

    function automatic int m_lookup();
        int a, b;
        if (m_ch) begin
            a = (m_x > 0) ? m_chroma[m_c][m_x-1][m_y] : m_left_c[m_c][m_y];
            b = (m_y > 0) ? m_chroma[m_c][m_x][m_y-1] : m_top_c[m_mbx][m_c][m_x];
        end else begin
            a = (m_x > 0) ? m_luma[m_x-1][m_y] : m_left_l[m_y];
            b = (m_y > 0) ? m_luma[m_x][m_y-1] : m_top_l[m_mbx][m_x];
        end
        case (m_nv)
            2'b11:   return (a + b + 1) / 2;
            2'b01:   return a;
            2'b10:   return b;
            default: return 0;
        endcase
    endfunction

    // Apply one clock edge's worth of inputs to the model.
    task automatic model_update();
        int tv;
        if (bus.NEWSLICE) begin
            model_clear();
            return;
        end
        tv = int'(bus.TOTALCOEFF);
`ifdef NC_TCCHECK_EN
        if (bus.TCVALID && tv > 16) begin
            tv = 16;
            m_err = 1;
        end
`endif
        if (bus.TCVALID) begin
            if (m_ch) m_chroma[m_c][m_x][m_y] = tv;
            else      m_luma[m_x][m_y] = tv;
        end
        m_exp_v = m_pend;
        if (m_pend) exp_q.push_back(5'(m_lookup()));
        if (bus.NXINC) begin
            for (int i = 0; i < 4; i++) begin
                m_left_l[i] = m_luma[3][i];
                m_top_l[m_mbx][i] = m_luma[i][3];
            end
            for (int c = 0; c < 2; c++) for (int i = 0; i < 2; i++) begin
                m_left_c[c][i] = m_chroma[c][1][i];
                m_top_c[m_mbx][c][i] = m_chroma[c][i][1];
            end
            m_mbx = (m_mbx + 1) % MAXMBW;
        end
        if (bus.NEWLINE) begin
            m_mbx = 0;
            model_clear_left();
        end
        if (bus.NLOAD) begin
            m_ch = bus.NX[2] | bus.NY[2];
            m_nv = bus.NV;
            if (m_ch) begin
                m_x = int'(bus.NX[0]); m_y = int'(bus.NY[0]); m_c = int'(bus.NY[1]);
            end else begin
                m_x = int'(bus.NX[1:0]); m_y = int'(bus.NY[1:0]); m_c = 0;
            end
        end
        m_pend = bus.NLOAD;
    endtask

    // Compare process: every cycle while out of reset.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("noutvalid", int'(bus.NOUTVALID), int'(m_exp_v));
            check("tcerr", int'(bus.TCERR), int'(m_err));
            if (m_exp_v) begin
                if (exp_q.size() == 0) begin
                    check("exp_q_underflow", 1, 0);
                end else begin
                    logic [4:0] e;
                    e = exp_q.pop_front();
                    check("nout", int'(bus.NOUT), int'(e));
                end
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge CLK);
        model_update();
        #1;
        bus.NLOAD = 0; bus.TCVALID = 0; bus.NXINC = 0; bus.NEWLINE = 0; bus.NEWSLICE = 0;
    endtask

    task automatic load(input logic [2:0] nx, input logic [2:0] ny, input logic [1:0] nv);
        bus.NLOAD = 1; bus.NX = nx; bus.NY = ny; bus.NV = nv;
        tick();
    endtask

    task automatic write_tc(input logic [4:0] tc);
        bus.TCVALID = 1; bus.TOTALCOEFF = tc;
        tick();
    endtask

    task automatic put(input logic [2:0] nx, input logic [2:0] ny, input logic [4:0] tc);
        load(nx, ny, 2'b00);
        write_tc(tc);
    endtask

    task automatic lookup_lit(input string name, input logic [2:0] nx, input logic [2:0] ny,
                              input logic [1:0] nv, input int lit);
        load(nx, ny, nv);
        tick();
        check({name, "_valid"}, int'(bus.NOUTVALID), 1);
        check(name, int'(bus.NOUT), lit);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.NEWSLICE = 0; bus.NEWLINE = 0; bus.NLOAD = 0; bus.NX = 0; bus.NY = 0;
        bus.NV = 0; bus.NXINC = 0; bus.TCVALID = 0; bus.TOTALCOEFF = 0;
        model_clear();
        for (int mb = 0; mb < MAXMBW; mb++) begin
            for (int x = 0; x < 4; x++) m_top_l[mb][x] = 0;
            for (int c = 0; c < 2; c++) for (int x = 0; x < 2; x++) m_top_c[mb][c][x] = 0;
        end
        repeat (3) @(posedge CLK);
        #1 RSTN = 1;
        check("rst_nout", int'(bus.NOUT), 0);
        check("rst_noutvalid", int'(bus.NOUTVALID), 0);
        check("rst_tcerr", int'(bus.TCERR), 0);
        chk_en = 1;

        // Slice start, then a lookup with no neighbours.
        bus.NEWSLICE = 1; tick();
        load(3'b000, 3'b000, 2'b00);
        check("lat1_not_yet_valid", int'(bus.NOUTVALID), 0);
        tick();
        check("lat2_valid", int'(bus.NOUTVALID), 1);
        check("none_avail", int'(bus.NOUT), 0);

        // Luma left and averaged neighbours.
        put(3'b000, 3'b000, 5'd5);
        lookup_lit("luma_a_only", 3'b001, 3'b000, 2'b01, 5);
        put(3'b000, 3'b001, 5'd3);
        put(3'b001, 3'b000, 5'd7);
        lookup_lit("luma_avg", 3'b001, 3'b001, 2'b11, 5);

        // MB commit into the left column.
        put(3'b011, 3'b000, 5'd4);
        put(3'b011, 3'b001, 5'd8);
        put(3'b011, 3'b010, 5'd12);
        put(3'b011, 3'b011, 5'd16);
        bus.NXINC = 1; tick();
        lookup_lit("left_commit", 3'b000, 3'b010, 2'b01, 12);
        lookup_lit("left_commit_y0", 3'b000, 3'b000, 2'b01, 4);

        // Top row: new line, fill bottom rows, commit together with NEWLINE.
        bus.NEWLINE = 1; tick();
        put(3'b000, 3'b011, 5'd2);
        put(3'b001, 3'b011, 5'd4);
        put(3'b010, 3'b011, 5'd6);
        put(3'b011, 3'b011, 5'd8);
        put(3'b101, 3'b111, 5'd9);
        bus.NXINC = 1; bus.NEWLINE = 1; tick();
        lookup_lit("top_luma", 3'b010, 3'b000, 2'b10, 6);
        lookup_lit("top_cr", 3'b101, 3'b110, 2'b10, 9);
        lookup_lit("left_cleared", 3'b000, 3'b001, 2'b01, 0);

        // Writeback and NLOAD in the same cycle.
        load(3'b000, 3'b000, 2'b00);
        bus.TCVALID = 1; bus.TOTALCOEFF = 5'd11;
        bus.NLOAD = 1; bus.NX = 3'b001; bus.NY = 3'b000; bus.NV = 2'b01;
        tick();
        tick();
        check("simul_valid", int'(bus.NOUTVALID), 1);
        check("simul_nout", int'(bus.NOUT), 11);

        // Back-to-back lookups across all luma and chroma positions.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] p;
            p = 4'(i);
            load({1'b0, p[1:0]}, {1'b0, p[3:2]}, 2'(3 - (i % 4)));
        end
        for (int i = 0; i < 8; i++) begin
            logic [2:0] p;
            p = 3'(i);
            load({2'b10, p[0]}, {1'b1, p[2], p[1]}, 2'(i % 4));
        end
        tick(); tick();

        // Column counter wraps after MAXMBW commits.
        repeat (MAXMBW) begin
            bus.NXINC = 1; tick();
        end
        lookup_lit("mbx_wrap_top", 3'b001, 3'b000, 2'b10, 4);

        // TotalCoeff range handling.
        put(3'b010, 3'b010, 5'd20);
`ifdef NC_TCCHECK_EN
        check("tcerr_set", int'(bus.TCERR), 1);
        lookup_lit("tc_clamped", 3'b011, 3'b010, 2'b01, 16);
`else
        check("tcerr_low", int'(bus.TCERR), 0);
        lookup_lit("tc_raw", 3'b011, 3'b010, 2'b01, 20);
`endif

        // NEWSLICE clears state and swallows a same-cycle NLOAD.
        bus.NEWSLICE = 1; bus.NLOAD = 1; bus.NX = 3'b001; bus.NY = 3'b000; bus.NV = 2'b01;
        tick();
        tick();
        check("slice_nload_ignored", int'(bus.NOUTVALID), 0);
        check("slice_tcerr", int'(bus.TCERR), 0);
        lookup_lit("slice_grid_clear", 3'b001, 3'b000, 2'b01, 0);

        // Asynchronous reset in the middle of a lookup stream.
        put(3'b000, 3'b000, 5'd13);
        load(3'b001, 3'b000, 2'b01);
        load(3'b001, 3'b000, 2'b01);
        check("pre_reset_valid", int'(bus.NOUTVALID), 1);
        check("pre_reset_nout", int'(bus.NOUT), 13);
        #2;
        chk_en = 0;
        RSTN = 0;
        #1;
        check("async_rst_valid", int'(bus.NOUTVALID), 0);
        check("async_rst_nout", int'(bus.NOUT), 0);
        model_clear();
        repeat (2) @(posedge CLK);
        #2 RSTN = 1;
        chk_en = 1;
        lookup_lit("post_reset_grid", 3'b001, 3'b000, 2'b01, 0);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
